// File: rtl/mmio_ctrl_pkg.sv
// Shared MMIO constants: select code, register offsets and the seven-segment decode table.
package mmio_ctrl_pkg;

  localparam int DATA_WID = 32;
  localparam logic [3:0] MMIO_SEL = 4'hF;

  localparam logic [2:0] SW_OFF      = 3'd0;
  localparam logic [2:0] BTN_OFF     = 3'd1;
  localparam logic [2:0] BTN_EVT_OFF = 3'd2;
  localparam logic [2:0] LED_OFF     = 3'd3;
  localparam logic [2:0] SEG_OFF     = 3'd4;
  localparam logic [2:0] TIMER_OFF   = 3'd5;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// Per-bit 2-flop synchroniser and stability counter; rise pulses fire on the edge the level is accepted.
module mmio_debounce #(
  parameter int WID             = 5,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] raw,
  output logic [WID-1:0] level,
  output logic [WID-1:0] rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WID-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WID; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept  = (s2[i] != level[i]) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise[i] = accept && s2[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt      <= '0;
        level[i] <= 1'b0;
      end else if (s2[i] == level[i]) begin
        cnt <= '0;
      end else if (accept) begin
        cnt      <= '0;
        level[i] <= s2[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Board MMIO peer of data memory: switches, buttons, LEDs, scanned 7-seg and a cycle timer.
// Reads are combinational so uncached loads complete in the cycle the address is presented.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_CYCLES     = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WID-1:0] addr,
  input  logic [DATA_WID-1:0] wdata,
  input  logic                we,
  output logic [DATA_WID-1:0] rdata,
  input  logic [15:0]         sw,
  input  logic [4:0]          btn,
  output logic [15:0]         led,
  output logic [7:0]          seg_an,
  output logic [7:0]          seg_cat
);

  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [2:0]          off;
  logic [15:0]         sw_s1, sw_s2;
  logic [4:0]          btn_lvl, btn_rise, btn_evt, evt_clr;
  logic [DATA_WID-1:0] seg_r, timer;
  logic [SCW-1:0]      scan_cnt;
  logic [2:0]          idx;
  logic                wr_led, wr_seg, wr_timer, wr_evt;
  logic                unused_addr;

  assign off         = addr[4:2];
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign wr_led   = we && (off == LED_OFF);
  assign wr_seg   = we && (off == SEG_OFF);
  assign wr_timer = we && (off == TIMER_OFF);
  assign wr_evt   = we && (off == BTN_EVT_OFF);
  assign evt_clr  = wr_evt ? wdata[4:0] : 5'b0;

  mmio_debounce #(
    .WID            (5),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn),
    .level(btn_lvl),
    .rise (btn_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      led      <= '0;
      seg_r    <= '0;
      timer    <= '0;
      btn_evt  <= '0;
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (wr_led) led <= wdata[15:0];
      if (wr_seg) seg_r <= wdata;
      timer   <= wr_timer ? wdata : timer + 32'd1;
      // A press landing on the same edge as its W1C must not be lost.
      btn_evt <= (btn_evt & ~evt_clr) | btn_rise;
      if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCW'(1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      SW_OFF:      rdata = {16'b0, sw_s2};
      BTN_OFF:     rdata = {27'b0, btn_lvl};
      BTN_EVT_OFF: rdata = {27'b0, btn_evt};
      LED_OFF:     rdata = {16'b0, led};
      SEG_OFF:     rdata = seg_r;
      TIMER_OFF:   rdata = timer;
      default:     rdata = '0;
    endcase
  end

  assign seg_an  = ~(8'b1 << idx);
  assign seg_cat = seg7(seg_r[{idx, 2'b00} +: 4]);

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with short debounce and scan periods.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [15:0] sw, led;
  logic [4:0]  btn;
  logic [7:0]  seg_an, seg_cat;

  int checks = 0;
  int errors = 0;

  logic [7:0] cat_tab [0:7];

  mmio_ctrl #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .sw(sw), .btn(btn), .led(led), .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; sw = '0; btn = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    checks++;
    if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      errors++;
      $display("FAIL reset_seg an=%h cat=%h want FE C0", seg_an, seg_cat);
    end
    checks++;
    if (led !== 16'h0) begin
      errors++;
      $display("FAIL reset_led got %h want 0000", led);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      addr = 32'(i * 4);
      #1;
      exp = (i == 5) ? 32'(i) : 32'h0;
      checks++;
      if (rdata !== exp) begin
        errors++;
        $display("FAIL reset_read off=%0d got %h want %h", i, rdata, exp);
      end
      tick();
    end
  endtask

  task automatic test_sw_led();
    sw = 16'hA5C3; addr = 32'h0;
    tick();
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_early got %h want 00000000", rdata);
    end
    tick();
    checks++;
    if (rdata !== 32'h0000A5C3) begin
      errors++;
      $display("FAIL sw_sync got %h want 0000A5C3", rdata);
    end
    addr = 32'hC; wdata = 32'hFFFF1234; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (led !== 16'h1234 || rdata !== 32'h00001234) begin
      errors++;
      $display("FAIL led_write led=%h rd=%h want 1234 00001234", led, rdata);
    end
    // Offsets 6/7 must ignore stores and still read zero.
    addr = 32'h18; wdata = 32'hDEADBEEF; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL off6_write got %h want 00000000", rdata);
    end
  endtask

  task automatic test_debounce();
    addr = 32'h4;
    for (int g = 0; g < 3; g++) begin
      btn = 5'b00100; tick(); tick(); tick();
      btn = 5'b00000; tick(); tick(); tick();
    end
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL glitch_btn got %h want 00000000", rdata);
    end
    btn = 5'b00100;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL btn_early got %h want 00000000", rdata);
    end
    tick();
    checks++;
    if (rdata !== 32'h4) begin
      errors++;
      $display("FAIL btn_level got %h want 00000004", rdata);
    end
    addr = 32'h8;
    #1;
    checks++;
    if (rdata !== 32'h4) begin
      errors++;
      $display("FAIL btn_evt got %h want 00000004", rdata);
    end
    wdata = 32'h4; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL evt_w1c got %h want 00000000", rdata);
    end
  endtask

  task automatic test_evt_collision();
    btn = 5'b00101; addr = 32'h8;
    for (int c = 0; c < 5; c++) tick();
    wdata = 32'h1; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL evt_set_wins got %h want 00000001", rdata);
    end
    wdata = 32'h1; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL evt_clear got %h want 00000000", rdata);
    end
  endtask

  task automatic test_timer();
    logic [31:0] exp [0:2];
    exp[0] = 32'hFFFFFFFE; exp[1] = 32'hFFFFFFFF; exp[2] = 32'h0;
    addr = 32'h14; wdata = 32'hFFFFFFFE; we = 1'b1;
    tick();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdata !== exp[i]) begin
        errors++;
        $display("FAIL timer_wrap step=%0d got %h want %h", i, rdata, exp[i]);
      end
      tick();
    end
    wdata = 32'hFFFFFFFF; we = 1'b1;
    tick();
    wdata = 32'h12345678;
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL timer_wrap_load got %h want 12345678", rdata);
    end
    tick();
    checks++;
    if (rdata !== 32'h12345679) begin
      errors++;
      $display("FAIL timer_post_load got %h want 12345679", rdata);
    end
  endtask

  task automatic test_scan();
    rst = 1'b1; btn = '0;
    tick();
    rst = 1'b0;
    addr = 32'h10; wdata = 32'h76543210; we = 1'b1;
    // Edges counted from the reset edge; scan index = (n/2) mod 8.
    for (int n = 1; n <= 18; n++) begin
      int          k;
      logic [7:0]  an_exp;
      tick();
      we = 1'b0;
      k = (n / 2) % 8;
      an_exp = ~(8'b1 << k);
      checks++;
      if (seg_an !== an_exp || seg_cat !== cat_tab[k]) begin
        errors++;
        $display("FAIL scan n=%0d an=%h cat=%h want %h %h", n, seg_an, seg_cat, an_exp, cat_tab[k]);
      end
    end
  endtask

  task automatic test_midreset();
    tick();
    rst = 1'b1; addr = 32'hC; wdata = 32'hFFFF; we = 1'b1;
    tick();
    we = 1'b0;
    rst = 1'b0;
    checks++;
    if (seg_an !== 8'hFE || seg_cat !== 8'hC0 || led !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset an=%h cat=%h led=%h want FE C0 0000", seg_an, seg_cat, led);
    end
    addr = 32'h14;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_timer got %h want 00000000", rdata);
    end
  endtask

  initial begin
    cat_tab[0] = 8'hC0; cat_tab[1] = 8'hF9; cat_tab[2] = 8'hA4; cat_tab[3] = 8'hB0;
    cat_tab[4] = 8'h99; cat_tab[5] = 8'h92; cat_tab[6] = 8'h82; cat_tab[7] = 8'hF8;
    test_reset();
    test_sw_led();
    test_debounce();
    test_evt_collision();
    test_timer();
    test_scan();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
